// File: rtl/sdram_arbiter_if.sv
// Requester and controller side bundle for the two-port SDRAM command arbiter.
// slave = arbiter view, master = requesters/controller view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rvalid0, rvalid1, rdata,
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data,
    output err
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rvalid0, rvalid1, rdata,
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rd_valid, rd_data,
    input  err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin two-port arbiter in front of the SDRAM controller command port.
// Outstanding reads are tagged with their port so in-order data is steered back.
module sdram_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input logic CLOCK_100,
  input logic rst,
  sdram_arbiter_if.slave bus
);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              grant, last_grant, pick;
  logic              elig0, elig1, go, accept;
  logic              push, pop, full, empty, head;
  logic [PW:0]       count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [TAG_DEPTH-1:0] tags;
  logic              cmd_we, err;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign elig0 = bus.req0 & (bus.we0 | ~full);
  assign elig1 = bus.req1 & (bus.we1 | ~full);
  assign go     = (state == IDLE) & (elig0 | elig1);
  assign accept = (state == BUSY) & bus.cmd_ready;
  assign push   = accept & ~cmd_we;
  assign pop    = bus.rd_valid & ~empty;
  assign head   = tags[rd_ptr];

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      elig0 & elig1:  pick = ~last_grant;
      elig1 & ~elig0: pick = 1'b1;
      default:        pick = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = BUSY;
      BUSY:    if (bus.cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_100 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // last_grant resets to 1 so port 0 wins the first tie
  always_ff @(posedge CLOCK_100 or posedge rst) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      if (go) begin
        grant     <= pick;
        cmd_we    <= pick ? bus.we1 : bus.we0;
        cmd_addr  <= pick ? bus.addr1 : bus.addr0;
        cmd_wdata <= pick ? bus.wdata1 : bus.wdata0;
      end
      if (accept) last_grant <= grant;
      if (bus.rd_valid & empty) err <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_100 or posedge rst) begin
    if (rst) begin
      tags   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= grant;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.cmd_valid = (state == BUSY);
  assign bus.cmd_we    = cmd_we;
  assign bus.cmd_addr  = cmd_addr;
  assign bus.cmd_wdata = cmd_wdata;
  assign bus.ack0      = accept & ~grant;
  assign bus.ack1      = accept & grant;
  assign bus.rvalid0   = pop & ~head;
  assign bus.rvalid1   = pop & head;
  assign bus.rdata     = bus.rd_data;
  assign bus.err       = err;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: per-cycle vector table plus
// hand sequences for FIFO-full, back-pressure, reset and spurious returns.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TAG_DEPTH(4)) dut (
    .CLOCK_100(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        req0, we0;
    logic [23:0] addr0;
    logic [15:0] wdata0;
    logic        req1, we1;
    logic [23:0] addr1;
    logic [15:0] wdata1;
    logic        rdy, rdv;
    logic [15:0] rdd;
    logic        e_ack0, e_ack1, e_cv;
    logic [23:0] e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    logic        e_rv0, e_rv1;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit p, input logic we, input logic [23:0] a,
                       input logic [15:0] d, input string nm);
    bit got = 1'b0;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (p ? bus.ack1 : bus.ack0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, 32'(got), 1);
    tick();
    if (p) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
  endtask

  localparam logic [23:0] A0 = 24'h000100;
  localparam logic [23:0] A1 = 24'h000200;

  initial begin
    // inputs | expected: ack0 ack1 cv addr we wdata rv0 rv1
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1, 1, A0, 16'h00A0, 1, 1, A1, 16'h00B1, 1, 0, 16'h0,
                 0, 0, 0, 24'h0, 0, 16'h0, 0, 0};
    for (int i = 1; i < 8; i += 4) begin
      tbl[i].e_ack0 = 1; tbl[i].e_cv = 1; tbl[i].e_addr = A0;
      tbl[i].e_we = 1; tbl[i].e_wdata = 16'h00A0;
      tbl[i+2].e_ack1 = 1; tbl[i+2].e_cv = 1; tbl[i+2].e_addr = A1;
      tbl[i+2].e_we = 1; tbl[i+2].e_wdata = 16'h00B1;
    end
    tbl[8]  = '{1, 1, 24'h000123, 16'hBEEF, 0, 0, 24'h0, 16'h0, 1, 0, 16'h0,
                0, 0, 0, 24'h0, 0, 16'h0, 0, 0};
    tbl[9]  = '{1, 1, 24'h000123, 16'hBEEF, 0, 0, 24'h0, 16'h0, 1, 0, 16'h0,
                1, 0, 1, 24'h000123, 1, 16'hBEEF, 0, 0};
    tbl[10] = '{0, 0, 24'h0, 16'h0, 1, 0, 24'h000010, 16'h0, 1, 0, 16'h0,
                0, 0, 0, 24'h0, 0, 16'h0, 0, 0};
    tbl[11] = '{0, 0, 24'h0, 16'h0, 1, 0, 24'h000010, 16'h0, 1, 0, 16'h0,
                0, 1, 1, 24'h000010, 0, 16'h0, 0, 0};
    tbl[12] = '{1, 0, 24'h000020, 16'h0, 0, 0, 24'h0, 16'h0, 1, 0, 16'h0,
                0, 0, 0, 24'h0, 0, 16'h0, 0, 0};
    tbl[13] = '{1, 0, 24'h000020, 16'h0, 0, 0, 24'h0, 16'h0, 1, 0, 16'h0,
                1, 0, 1, 24'h000020, 0, 16'h0, 0, 0};
    tbl[14] = '{0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 1, 1, 16'h1111,
                0, 0, 0, 24'h0, 0, 16'h0, 0, 1};
    tbl[15] = '{0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 1, 1, 16'h2222,
                0, 0, 0, 24'h0, 0, 16'h0, 1, 0};
    tbl[16] = '{0, 0, 24'h0, 16'h0, 0, 0, 24'h0, 16'h0, 1, 0, 16'h0,
                0, 0, 0, 24'h0, 0, 16'h0, 0, 0};

    rst = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.cmd_ready = 1'b1; bus.rd_valid = 1'b0; bus.rd_data = '0;
    tick();
    @(negedge clk);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    chk("rst_ack", 32'({bus.ack0, bus.ack1}), 0);
    chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    chk("rst_cmd_addr", 32'(bus.cmd_addr), 0);
    chk("rst_cmd_wdata", 32'(bus.cmd_wdata), 0);
    chk("rst_err", 32'(bus.err), 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.req0 = tbl[i].req0; bus.we0 = tbl[i].we0;
      bus.addr0 = tbl[i].addr0; bus.wdata0 = tbl[i].wdata0;
      bus.req1 = tbl[i].req1; bus.we1 = tbl[i].we1;
      bus.addr1 = tbl[i].addr1; bus.wdata1 = tbl[i].wdata1;
      bus.cmd_ready = tbl[i].rdy;
      bus.rd_valid = tbl[i].rdv; bus.rd_data = tbl[i].rdd;
      @(negedge clk);
      chk($sformatf("r%0d_ack0", i), 32'(bus.ack0), 32'(tbl[i].e_ack0));
      chk($sformatf("r%0d_ack1", i), 32'(bus.ack1), 32'(tbl[i].e_ack1));
      chk($sformatf("r%0d_cv", i), 32'(bus.cmd_valid), 32'(tbl[i].e_cv));
      chk($sformatf("r%0d_rv0", i), 32'(bus.rvalid0), 32'(tbl[i].e_rv0));
      chk($sformatf("r%0d_rv1", i), 32'(bus.rvalid1), 32'(tbl[i].e_rv1));
      chk($sformatf("r%0d_err", i), 32'(bus.err), 0);
      if (tbl[i].e_cv) begin
        chk($sformatf("r%0d_addr", i), 32'(bus.cmd_addr),
            32'(tbl[i].e_addr));
        chk($sformatf("r%0d_we", i), 32'(bus.cmd_we), 32'(tbl[i].e_we));
        chk($sformatf("r%0d_wdata", i), 32'(bus.cmd_wdata),
            32'(tbl[i].e_wdata));
      end
      if (tbl[i].rdv)
        chk($sformatf("r%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].rdd));
      tick();
    end

    // fill the tag FIFO with four reads on port 0
    for (int i = 0; i < 4; i++)
      issue(1'b0, 1'b0, 24'h000400 + 24'(i), 16'h0, "fill_read_ack");
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 24'h000500;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 24'h000600;
    bus.wdata1 = 16'h6666;
    @(negedge clk);
    chk("full_idle_cv", 32'(bus.cmd_valid), 0);
    tick();
    @(negedge clk);
    chk("full_write_ack1", 32'(bus.ack1), 1);
    chk("full_write_ack0", 32'(bus.ack0), 0);
    chk("full_write_addr", 32'(bus.cmd_addr), 32'h600);
    tick();
    bus.req1 = 0;
    @(negedge clk);
    chk("full_read_held_cv", 32'(bus.cmd_valid), 0);
    tick();
    bus.rd_valid = 1; bus.rd_data = 16'hCAFE;
    @(negedge clk);
    chk("full_pop_rv0", 32'(bus.rvalid0), 1);
    chk("full_pop_rdata", 32'(bus.rdata), 32'hCAFE);
    chk("full_pop_cv", 32'(bus.cmd_valid), 0);
    tick();
    bus.rd_valid = 0;
    @(negedge clk);
    chk("after_pop_idle_cv", 32'(bus.cmd_valid), 0);
    tick();
    @(negedge clk);
    chk("after_pop_cv", 32'(bus.cmd_valid), 1);
    chk("after_pop_ack0", 32'(bus.ack0), 1);
    chk("after_pop_addr", 32'(bus.cmd_addr), 32'h500);
    tick();
    bus.req0 = 0;

    // back-pressure then reset in the middle of BUSY
    bus.cmd_ready = 0;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 24'h0ABCDE;
    bus.wdata1 = 16'h5A5A;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_cv", i), 32'(bus.cmd_valid), 1);
      chk($sformatf("bp%0d_addr", i), 32'(bus.cmd_addr), 32'h0ABCDE);
      chk($sformatf("bp%0d_wdata", i), 32'(bus.cmd_wdata), 32'h5A5A);
      chk($sformatf("bp%0d_ack", i), 32'({bus.ack0, bus.ack1}), 0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midbusy_rst_cv", 32'(bus.cmd_valid), 0);
    bus.req1 = 0; bus.cmd_ready = 1;
    @(negedge clk);
    chk("midbusy_rst_addr", 32'(bus.cmd_addr), 0);
    tick();
    rst = 1'b0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 24'h000700;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 24'h000701;
    tick();
    @(negedge clk);
    chk("tie_after_rst_ack0", 32'(bus.ack0), 1);
    chk("tie_after_rst_ack1", 32'(bus.ack1), 0);
    tick();
    bus.req0 = 0; bus.req1 = 0;

    // spurious return: the reset must have emptied the tag FIFO
    bus.rd_valid = 1; bus.rd_data = 16'hDEAD;
    @(negedge clk);
    chk("spur_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    chk("spur_rdata", 32'(bus.rdata), 32'hDEAD);
    tick();
    bus.rd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("err_sticky%0d", i), 32'(bus.err), 1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("err_cleared", 32'(bus.err), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter that shares the single command port of the SDRAM controller in `top` between two requesters: the button-driven pattern writer/checker and the LED status reader. It registers and issues one command at a time to the controller and tracks outstanding reads in a 4-entry tag FIFO. Read data returned in order is steered back to the requester that issued the read.

## Interface
- `ADDR_W`, 24: word address width (2 bank + 13 row + 9 column, IS42S16160).
- `DATA_W`, 16: data width.
- `TAG_DEPTH`, 4: maximum outstanding reads; power of two.

Ports (one clock; reset is asynchronous and active-high):
- `CLOCK_100`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request; held high with fields stable until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `ack0`, `ack1`  out  1  one-cycle pulse: the command has been accepted by the controller.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` belongs to this port.
- `rdata`  out  DATA_W  read data, shared by both ports.
- `cmd_valid`  out  1  command presented to the controller.
- `cmd_ready`  in  1  controller accepts the command this cycle.
- `cmd_we`, `cmd_addr`, `cmd_wdata`  out  1/ADDR_W/DATA_W  registered command fields.
- `rd_valid`  in  1  controller read-data strobe; returns reads in issue order.
- `rd_data`  in  DATA_W  controller read data.
- `err`  out  1  sticky flag: `rd_valid` arrived with the tag FIFO empty.

## Operation
- States: IDLE and BUSY.
- **IDLE:**
  - A port is eligible if its `req` is high and either its `we` = 1 or the tag FIFO is not full.
  - If no port is eligible, stay in IDLE.
  - If exactly one port is eligible, grant it.
  - If both are eligible, grant the port not equal to `last_grant`.
  - On a grant: latch `we`/`addr`/`wdata` into the `cmd_*` registers, set `grant`, set `cmd_valid` = 1, and go to BUSY.
- **BUSY:**
  - `cmd_valid` stays high and the `cmd_*` fields stay stable until `cmd_ready` = 1.
  - In the `cmd_ready` cycle:
    - `ack[grant]` = 1 (combinational from state, `grant` and `cmd_ready`).
    - At the clock edge, `last_grant` ← `grant`, `cmd_valid` ← 0, and the state returns to IDLE.
    - If `cmd_we` = 0, push `grant` into the tag FIFO.
- **Read return:**
  - When `rd_valid` = 1 and the FIFO is not empty, `rvalid[head]` is high that same cycle, `rdata` = `rd_data` (combinational pass-through), and the head is popped.
  - A push and a pop in the same cycle leave the count unchanged.
  - FIFO state: 3-bit count (0..4) and 2-bit read/write pointers that wrap modulo 4.
- **Error case:** `rd_valid` with the FIFO empty: no `rvalid` pulse, `err` ← 1. Only `rst` clears `err`.
- **FIFO full (count = 4):** read requests are not granted; write requests still are. A pending read becomes eligible the cycle after a pop.
- **Reset, including mid-command:**
  - State = IDLE, `cmd_valid` = 0, `cmd_*` = 0, `grant` = 0, `last_grant` = 1 (so port 0 wins the first tie), FIFO count and pointers = 0, `err` = 0.
  - Outstanding reads are forgotten.

## Timing
- Arbitration takes one cycle (IDLE), so the fastest issue rate is one command every 2 cycles.
- `req` high at edge N (in IDLE) → `cmd_valid` high from edge N+1 → `ack` in the first cycle with `cmd_ready` = 1, at the earliest the cycle after edge N+1.
- The requester must drop `req`, or present its next command, at the edge ending the ack cycle. The arbiter samples `req` again in IDLE in the following cycle.
- `rvalid` has zero latency from `rd_valid`.
- The tag push from an accept becomes visible at the next edge. A `rd_valid` in the same cycle as the accept of its own read is not legal from the controller.
- Reset values of outputs: `ack*` = 0, `rvalid*` = 0, `cmd_valid` = 0, `cmd_*` = 0, `err` = 0. `rdata` follows `rd_data`.

## Test plan
- **Single write:** `req0`=1, `we0`=1, `addr0`=0x000123, `wdata0`=0xBEEF, `cmd_ready` tied 1 → `cmd_valid` one cycle later with `cmd_addr`=0x000123 and `cmd_wdata`=0xBEEF; `ack0` pulses exactly one cycle; `ack1` stays 0.
- **Round-robin tie:** `req0` and `req1` held high, both writes → grants alternate 0,1,0,1 starting with port 0; each ack is 2 cycles apart.
- **Read steering:**
  - Port 1 reads 0x000010, then port 0 reads 0x000020.
  - Controller returns `rd_data` 0x1111, then 0x2222.
  - Required: `rvalid1` with 0x1111, then `rvalid0` with 0x2222.
- **FIFO full:**
  - Issue 4 reads with no return, then a 5th read on port 0 plus a write on port 1 → the write is granted and the read is held.
  - After one `rd_valid`, the read is granted the next IDLE cycle.
- **Back-pressure and reset:**
  - `cmd_ready`=0 for 5 cycles → `cmd_*` stable and no ack.
  - Assert `rst` mid-BUSY → `cmd_valid`=0 immediately, FIFO empty; first tie after release goes to port 0.
- **Spurious return:** `rd_valid` with the FIFO empty → no `rvalid`; `err`=1 and it stays 1 until `rst`.
